// File: rtl/framebuffer_reader_pkg.sv
// Shared types for the frame buffer read path: request FSM states and RGB565 pixel.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package framebuffer_reader_pkg;

    localparam int PIXEL_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_CREDIT,
        ST_DRAIN
    } fb_state_t;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

endpackage

// File: rtl/framebuffer_reader_fifo.sv
// Synchronous pixel FIFO with registered storage; head is the oldest entry.
// Latency: a push becomes visible at the head one cycle later.
// Backpressure: none internally; the caller must never push when full (asserted).
//
// Ports: clk/reset_n; push + push_dat write; pop advances the head;
//        head, empty and count describe the current contents.
module fb_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_pop;

    assign empty  = (count == '0);
    assign full   = (count == CW'(DEPTH));
    assign do_pop = pop && !empty;
    assign head   = mem[rd_ptr];

    // Storage is not reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // The upstream credit scheme must make this impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n) !(push && full));

endmodule

// File: rtl/framebuffer_reader.sv
// Streams a stored RGB565 frame from SDRAM (Avalon-MM burst reads) to an Avalon-ST pixel sink.
// Latency: first read beat appears on st_valid one cycle after avm_readdatavalid.
// Backpressure: st_ready stalls the FIFO; bursts are only issued when FIFO space covers all outstanding words.
//
// Ports: clk/reset_n; enable runs frame fetching; fb_base is the frame byte address (sampled at frame start);
//        avm_* is the burst read master; st_* is the pixel stream with sop/eop framing; busy marks an active frame.
module framebuffer_reader
    import framebuffer_reader_pkg::*;
#(
    parameter int H_RES      = 320,
    parameter int V_RES      = 240,
    parameter int BURST_LEN  = 8,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic [31:0]          fb_base,
    output logic [31:0]          avm_address,
    output logic                 avm_read,
    output logic [3:0]           avm_burstcount,
    input  logic                 avm_waitrequest,
    input  logic [PIXEL_W-1:0]   avm_readdata,
    input  logic                 avm_readdatavalid,
    output logic [PIXEL_W-1:0]   st_data,
    output logic                 st_valid,
    input  logic                 st_ready,
    output logic                 st_sop,
    output logic                 st_eop,
    output logic                 busy
);

    localparam int TOTAL = H_RES * V_RES;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam int OUT_W = $clog2(FIFO_DEPTH + 1);

    fb_state_t          state;
    fb_state_t          state_nxt;
    logic [31:0]        addr;
    logic [CNT_W-1:0]   req_cnt;
    logic [CNT_W-1:0]   out_cnt;
    logic [OUT_W-1:0]   outstanding;
    logic [OUT_W-1:0]   fifo_cnt;
    logic               fifo_empty;
    rgb565_t            fifo_head;

    logic burst_acc;
    logic beat;
    logic pix_acc;
    logic last_pix;
    logic req_last;
    logic credit_ok;
    logic frame_start;

    assign burst_acc   = (state == ST_ISSUE) && !avm_waitrequest;
    // Beats in IDLE belong to bursts from before a reset and are dropped.
    assign beat        = avm_readdatavalid && (state != ST_IDLE);
    assign pix_acc     = st_valid && st_ready;
    assign last_pix    = pix_acc && st_eop;
    assign req_last    = (req_cnt == CNT_W'(TOTAL - BURST_LEN));
    // Free space minus words still in flight must cover one more burst.
    assign credit_ok   = (int'(fifo_cnt) + int'(outstanding) + BURST_LEN) <= FIFO_DEPTH;
    assign frame_start = enable && ((state == ST_IDLE) || ((state == ST_DRAIN) && last_pix));

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (enable) state_nxt = ST_WAIT_CREDIT;
            end
            ST_WAIT_CREDIT: begin
                if (credit_ok) state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (!avm_waitrequest) state_nxt = req_last ? ST_DRAIN : ST_WAIT_CREDIT;
            end
            ST_DRAIN: begin
                if (last_pix) state_nxt = enable ? ST_WAIT_CREDIT : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        avm_read = 1'b0;
        busy     = 1'b0;
        if (state == ST_ISSUE) avm_read = 1'b1;
        if (state != ST_IDLE)  busy     = 1'b1;
    end

    // Datapath counters; addr only moves on acceptance so the request holds under waitrequest.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr        <= '0;
            req_cnt     <= '0;
            out_cnt     <= '0;
            outstanding <= '0;
        end else begin
            if (frame_start) begin
                addr    <= fb_base;
                req_cnt <= '0;
            end else if (burst_acc) begin
                addr    <= addr + 32'(2 * BURST_LEN);
                req_cnt <= req_cnt + CNT_W'(BURST_LEN);
            end

            unique case ({burst_acc, beat})
                2'b10:   outstanding <= outstanding + OUT_W'(BURST_LEN);
                2'b01:   outstanding <= outstanding - OUT_W'(1);
                2'b11:   outstanding <= outstanding + OUT_W'(BURST_LEN - 1);
                default: outstanding <= outstanding;
            endcase

            if ((state == ST_IDLE) && enable) begin
                out_cnt <= '0;
            end else if (pix_acc) begin
                out_cnt <= st_eop ? '0 : out_cnt + CNT_W'(1);
            end
        end
    end

    fb_fifo #(
        .WIDTH (PIXEL_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (beat),
        .push_dat (avm_readdata),
        .pop      (pix_acc),
        .head     (fifo_head),
        .empty    (fifo_empty),
        .count    (fifo_cnt)
    );

    assign avm_address    = addr;
    assign avm_burstcount = 4'(BURST_LEN);
    assign st_valid       = !fifo_empty;
    assign st_data        = fifo_head;
    assign st_sop         = st_valid && (out_cnt == '0);
    assign st_eop         = st_valid && (out_cnt == CNT_W'(TOTAL - 1));

endmodule
